field_packer: RTL and testbench
===============================

// Module: field_packer
// PURPOSE
//  Downstream stage of the bit-field selection unit: consumes the 16-bit fields it extracts
//  and packs them, LSB-first, into 64-bit words for the wide datapath/store stage.
//  Valid/ready on both sides; a flush input emits a partially filled word at end of stream.
//  Accumulator and output register are decoupled, so filling continues while a word waits.
// PARAMETERS
//  FIELD_W  16  width of one input field in bits
//  FIELDS   4   fields per output word; out_word width = FIELD_W*FIELDS
// PORTS
//  clk        in   1                 single clock; all state changes on posedge
//  reset      in   1                 asynchronous, active-low reset
//  in_valid   in   1                 in_field is valid this cycle
//  in_field   in   FIELD_W           extracted field from the selection stage
//  in_ready   out  1                 packer can accept in_field this cycle
//  flush      in   1                 close the current partial word (single-cycle pulse)
//  out_valid  out  1                 out_word/out_count hold a word
//  out_ready  in   1                 consumer accepts the word this cycle
//  out_word   out  FIELD_W*FIELDS    packed word; field k at [FIELD_W*k+FIELD_W-1 : FIELD_W*k]
//  out_count  out  $clog2(FIELDS)+1  number of valid fields in out_word, 1..FIELDS
// BEHAVIOUR
//  - Reset (reset==0, async): out_valid=0, out_word=0, out_count=0, acc=0, acc_cnt=0,
//    state=ACCUM. Any partial word or held output is discarded, including mid-stream.
//  - Field accept: in_valid && in_ready. in_field is written to slot acc_cnt; acc_cnt increments.
//  - out_free = !out_valid || out_ready (combinational).
//  - in_ready = (state==ACCUM) && !(acc_cnt==FIELDS-1 && !out_free).
//  - Word completion: the accepted field fills slot FIELDS-1 and out_free is high.
//    Next edge: out_word<=acc including the new field, out_count<=FIELDS, out_valid<=1,
//    acc<=0, acc_cnt<=0. Latency: 1 cycle from last accept to out_valid.
//  - Output pop: out_valid && out_ready with no new word loaded -> out_valid<=0.
//    Pop and load in the same cycle gives back-to-back words; full rate is 1 field/cycle.
//  - Flush with effective count n>0 (n includes a field accepted in the same cycle):
//    if out_free, the word is moved next edge with out_count=n and unused slots zero.
//    Otherwise the FSM enters FLUSH_WAIT: in_ready=0 and acc is held until out_free,
//    then the word is moved and the FSM returns to ACCUM.
//  - Flush with n==0: no-op. No empty word is ever emitted.
//  - Flush during FLUSH_WAIT: ignored (already pending).
//  - FSM: ACCUM --flush && n>0 && !out_free--> FLUSH_WAIT --out_free--> ACCUM (word moved).
//  - Holding rule: out_word and out_count stay stable while out_valid && !out_ready.
//  - in_field is ignored when not accepted. No X propagates from unaccepted inputs.
// STRUCTURE
//  - field_packer_pkg: FIELD_W/FIELDS defaults, localparam CNT_W=$clog2(FIELDS)+1,
//    typedef enum {ACCUM, FLUSH_WAIT} packer_state_t.
//  - Single module. No sub-module is warranted; the output register lives inline.
//  - Slot writes use an indexed part-select acc[acc_cnt*FIELD_W +: FIELD_W].
// TESTING
//  - Basic pack: out_ready=1; send 0x0123,0x4567,0x89AB,0xCDEF on consecutive cycles
//    -> one cycle after the 4th: out_word=64'hCDEF_89AB_4567_0123, out_count=4, out_valid=1 for 1 cycle.
//  - Backpressure: out_ready=0; stream 0x0001..0x0008 -> 1st word held stable;
//    in_ready=0 after 0x0007 (acc_cnt==3); raise out_ready -> words ..0004_0003_0002_0001
//    then ..0008_0007_0006_0005, no loss or duplication.
//  - Partial flush: send 0x0012,0x0034, then flush -> out_word=64'h0000_0000_0034_0012, out_count=2.
//  - Flush+field same cycle: acc holds 0x00AA; in 0x00BB with flush
//    -> out_word=64'h0000_0000_00BB_00AA, out_count=2. Flush with empty acc -> out_valid stays 0.
//  - FLUSH_WAIT: output full, out_ready=0; 1 field then flush -> in_ready=0;
//    out_ready=1 -> held word popped, partial word (count 1) follows next cycle.
//  - Async reset mid-stream: assert reset between edges with acc_cnt=2 and out_valid=1
//    -> outputs 0 immediately; after release 4 fields give a clean word with no stale fields.

Source files
------------

// File: rtl/field_packer_pkg.sv
// Shared constants and types for the field packer: default geometry and FSM state type.
package field_packer_pkg;

    localparam int FIELD_W_DEF = 16;
    localparam int FIELDS_DEF  = 4;
    localparam int CNT_W       = $clog2(FIELDS_DEF) + 1;

    // ACCUM: filling the accumulator; FLUSH_WAIT: a flushed partial word waits for the output register.
    typedef enum logic [0:0] {
        ACCUM      = 1'b0,
        FLUSH_WAIT = 1'b1
    } packer_state_t;

endpackage

// File: rtl/field_packer.sv
// Packs FIELD_W-bit fields LSB-first into FIELD_W*FIELDS-bit words.
// The accumulator and the output register are independent, so the next word keeps
// filling while a finished word waits for the consumer.
//
// Handshake: a transfer happens on a posedge where valid && ready are both high.
// The producer holds data stable while valid && !ready; ready never depends on
// the same-side valid. in_ready is a function of state, acc_cnt and the output side;
// out_valid/out_word/out_count come straight from registers.
module field_packer
    import field_packer_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELDS  = FIELDS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [FIELD_W-1:0]            in_field,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FIELD_W*FIELDS-1:0]     out_word,
    output logic [$clog2(FIELDS):0]       out_count,
    output packer_state_t                 fsm_state
);

    localparam int CW = $clog2(FIELDS) + 1;
    localparam int WW = FIELD_W * FIELDS;
    localparam logic [CW-1:0] LAST_SLOT = CW'(FIELDS - 1);

    packer_state_t state;
    logic [WW-1:0] acc;
    logic [WW-1:0] acc_next;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] cnt_next;

    logic out_free;
    logic accept;
    logic complete;
    logic flush_req;
    logic move;

    assign fsm_state = state;
    assign out_free  = !out_valid || out_ready;
    // The last slot may only be taken when the finished word has somewhere to go.
    assign in_ready  = (state == ACCUM) && !(acc_cnt == LAST_SLOT && !out_free);
    assign accept    = in_valid && in_ready;
    // in_ready already guarantees out_free when the last slot is filled.
    assign complete  = accept && (acc_cnt == LAST_SLOT);
    // A flush that coincides with completion leaves nothing behind, so it is a no-op.
    assign flush_req = (state == ACCUM) && flush && (cnt_next != '0) && !complete;
    assign move      = complete
                     || (flush_req && out_free)
                     || ((state == FLUSH_WAIT) && out_free);

    // Accumulator contents and fill count including a field accepted this cycle.
    always_comb begin
        acc_next = acc;
        cnt_next = acc_cnt;
        if (accept) begin
            acc_next[int'(acc_cnt) * FIELD_W +: FIELD_W] = in_field;
            cnt_next = acc_cnt + CW'(1);
        end
    end

    // Accumulator, output register and flush FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACCUM;
            acc       <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_count <= '0;
        end else if (move) begin
            out_word  <= acc_next;
            out_count <= cnt_next;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_cnt   <= '0;
            state     <= ACCUM;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            acc     <= acc_next;
            acc_cnt <= cnt_next;
            if (flush_req) begin
                state <= FLUSH_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_field_packer.sv
// Directed bench for field_packer: inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that updates them.
module tb_field_packer;
    import field_packer_pkg::*;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [15:0]   in_field;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_word;
    logic [2:0]    out_count;
    packer_state_t fsm_state;

    int checks;
    int failures;

    field_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_field  (in_field),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .fsm_state (fsm_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one field (optionally with flush) for one cycle; it must be accepted.
    task automatic send(input logic [15:0] f, input logic fl);
        in_valid = 1'b1;
        in_field = f;
        flush    = fl;
        #1;
        check("send_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_field = 16'h0000;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] w, input logic [2:0] c);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_word"},  out_word, w);
        check({tag, "_count"}, 64'(out_count), 64'(c));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_field  = 16'h0000;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check_out("reset", 1'b0, 64'h0, 3'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_state", 64'(fsm_state), 64'(ACCUM));
        reset = 1'b1;
        @(negedge clk);

        // basic pack at full rate
        out_ready = 1'b1;
        send(16'h0123, 1'b0);
        send(16'h4567, 1'b0);
        send(16'h89AB, 1'b0);
        check("basic_not_yet", 64'(out_valid), 64'd0);
        send(16'hCDEF, 1'b0);
        check_out("basic", 1'b1, 64'hCDEF_89AB_4567_0123, 3'd4);
        @(negedge clk);
        check("basic_single_cycle", 64'(out_valid), 64'd0);

        // backpressure
        out_ready = 1'b0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        check_out("bp_first", 1'b1, 64'h0004_0003_0002_0001, 3'd4);
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        check_out("bp_held", 1'b1, 64'h0004_0003_0002_0001, 3'd4);
        in_valid = 1'b1;
        in_field = 16'h0008;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_out("bp_held2", 1'b1, 64'h0004_0003_0002_0001, 3'd4);
        out_ready = 1'b1;
        send(16'h0008, 1'b0);
        check_out("bp_second", 1'b1, 64'h0008_0007_0006_0005, 3'd4);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

        // partial flush
        send(16'h0012, 1'b0);
        send(16'h0034, 1'b0);
        pulse_flush();
        check_out("partial", 1'b1, 64'h0000_0000_0034_0012, 3'd2);
        @(negedge clk);
        check("partial_pop", 64'(out_valid), 64'd0);

        // flush together with a field, then flush of an empty accumulator
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b1);
        check_out("flush_field", 1'b1, 64'h0000_0000_00BB_00AA, 3'd2);
        @(negedge clk);
        check("flush_field_pop", 64'(out_valid), 64'd0);
        pulse_flush();
        check("empty_flush", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("empty_flush2", 64'(out_valid), 64'd0);

        // flush while the output register is occupied
        out_ready = 1'b0;
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0033, 1'b0);
        send(16'h0044, 1'b0);
        send(16'h0055, 1'b0);
        pulse_flush();
        #1;
        check("fw_state", 64'(fsm_state), 64'(FLUSH_WAIT));
        check("fw_in_ready", 64'(in_ready), 64'd0);
        check_out("fw_held", 1'b1, 64'h0044_0033_0022_0011, 3'd4);
        @(negedge clk);
        check("fw_still_waiting", 64'(fsm_state), 64'(FLUSH_WAIT));
        out_ready = 1'b1;
        @(negedge clk);
        check_out("fw_partial", 1'b1, 64'h0000_0000_0000_0055, 3'd1);
        check("fw_back_to_accum", 64'(fsm_state), 64'(ACCUM));
        @(negedge clk);
        check("fw_pop", 64'(out_valid), 64'd0);
        check("fw_in_ready_back", 64'(in_ready), 64'd1);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        send(16'h00E1, 1'b0);
        send(16'h00E2, 1'b0);
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_out("ar_async", 1'b0, 64'h0, 3'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        send(16'h00A1, 1'b0);
        send(16'h00A2, 1'b0);
        send(16'h00A3, 1'b0);
        send(16'h00A4, 1'b0);
        check_out("ar_clean", 1'b1, 64'h00A4_00A3_00A2_00A1, 3'd4);
        @(negedge clk);
        check("ar_pop", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
